gray_count_decoder: RTL

GRAY_COUNT_DECODER -- requirements
Module: gray_count_decoder

---
 rtl/gray_count_decoder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/gray_count_decoder.sv
// Two-stage Gray-to-binary decoder with step direction, wrap and error flags.
// Optional saturating error counter is enabled by defining GRAY_DEC_ERRCNT_EN.
module gray_count_decoder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             gray_valid,
    input  logic             err_clr,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             dir_up,
    output logic             dir_dn,
    output logic             wrap,
    output logic             step_err,
    output logic [7:0]       err_cnt
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
    localparam int unsigned      CNTW = 8;

    logic [WIDTH-1:0] s1_gray_q;
    logic             s1_vld_q;
    logic [WIDTH-1:0] bin_q;
    logic             have_prev_q;
    logic             bin_valid_q;
    logic             dir_up_q;
    logic             dir_dn_q;
    logic             wrap_q;
    logic             step_err_q;

    logic [WIDTH-1:0] bin_c;
    logic [WIDTH-1:0] diff_c;
    logic             up_c;
    logic             dn_c;
    logic             wrap_c;
    logic             err_c;

    // Stage 1: capture qualified samples; the valid bit follows every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_gray_q <= '0;
            s1_vld_q  <= 1'b0;
        end else begin
            s1_vld_q <= gray_valid;
            if (gray_valid) begin
                s1_gray_q <= gray_in;
            end
        end
    end

    // Gray-to-binary conversion and step classification against the last value.
    always_comb begin
        bin_c          = '0;
        bin_c[WIDTH-1] = s1_gray_q[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            bin_c[i] = bin_c[i+1] ^ s1_gray_q[i];
        end
        diff_c = bin_c - bin_q;
        up_c   = 1'b0;
        dn_c   = 1'b0;
        wrap_c = 1'b0;
        err_c  = 1'b0;
        if (s1_vld_q && have_prev_q) begin
            if (diff_c == ONE) begin
                up_c   = 1'b1;
                wrap_c = (bin_c == '0);
            end else if (diff_c == ONES) begin
                dn_c   = 1'b1;
                wrap_c = (bin_c == ONES);
            end else if (diff_c != '0) begin
                err_c  = 1'b1;
            end
        end
    end

    // Stage 2: registered outputs; bin_q doubles as the previous decoded value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_q       <= '0;
            have_prev_q <= 1'b0;
            bin_valid_q <= 1'b0;
            dir_up_q    <= 1'b0;
            dir_dn_q    <= 1'b0;
            wrap_q      <= 1'b0;
            step_err_q  <= 1'b0;
        end else begin
            bin_valid_q <= s1_vld_q;
            dir_up_q    <= up_c;
            dir_dn_q    <= dn_c;
            wrap_q      <= wrap_c;
            step_err_q  <= err_c;
            if (s1_vld_q) begin
                bin_q       <= bin_c;
                have_prev_q <= 1'b1;
            end
        end
    end

`ifdef GRAY_DEC_ERRCNT_EN
    logic [CNTW-1:0] err_cnt_q;
    logic [CNTW-1:0] err_cnt_d;

    // Clear wins over the count, but an error in the clear cycle still counts once.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = CNTW'(err_c);
        end else if (err_c && (err_cnt_q != {CNTW{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_cnt        = '0;
`endif

    assign bin_out   = bin_q;
    assign bin_valid = bin_valid_q;
    assign dir_up    = dir_up_q;
    assign dir_dn    = dir_dn_q;
    assign wrap      = wrap_q;
    assign step_err  = step_err_q;

endmodule
